// File: rtl/div_fixed_seq_if.sv
// Handshake bundle for div_fixed_seq: operand offer side and result side.
interface div_fixed_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q_o;
  logic             ovf_o;
  logic             dbz_o;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, signed_i, a_i, b_i, out_ready,
    input  in_ready, out_valid, q_o, ovf_o, dbz_o
  );

  // The divider itself.
  modport slave (
    input  in_valid, signed_i, a_i, b_i, out_ready,
    output in_ready, out_valid, q_o, ovf_o, dbz_o
  );
endinterface

// File: rtl/div_fixed_seq.sv
// Iterative restoring divider: q = (a << FRAC) / b, one quotient bit per clock.
// Signed or unsigned per operation, with divide-by-zero and overflow saturation.
module div_fixed_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic              clk,
  input  logic              rst,
  div_fixed_seq_if.slave    bus_io
);

  localparam int unsigned Iter = WIDTH + FRAC;
  localparam int unsigned CntW = $clog2(Iter + 1);
  localparam int unsigned ExtW = Iter + 1;

  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOne = {WIDTH{1'b1}};

  // Saturation thresholds on the zero-extended quotient magnitude.
  localparam logic [ExtW-1:0] LimU   = ExtW'(1) << WIDTH;
  localparam logic [ExtW-1:0] LimNeg = ExtW'(1) << (WIDTH - 1);
  localparam logic [ExtW-1:0] LimPos = LimNeg - ExtW'(1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             smode_q;
  logic             neg_q;
  logic [Iter-1:0]  dvd_q;   // remaining (|a| << FRAC) bits, MSB first
  logic [WIDTH-1:0] bm_q;
  logic [WIDTH:0]   rem_q;
  logic [Iter-1:0]  quo_q;
  logic [WIDTH-1:0] q_q;
  logic             ovf_q;
  logic             dbz_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] am_in;
  logic [WIDTH-1:0] bm_in;
  logic [WIDTH-1:0] dbz_val;

  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH:0]   rem_nx;
  logic [Iter-1:0]  quo_nx;
  logic [ExtW-1:0]  qm_ext;
  logic [WIDTH-1:0] q_lo;
  logic [WIDTH-1:0] fin_q;
  logic             fin_ovf;

  // Operand magnitudes and divide-by-zero result, taken straight off the bus.
  always_comb begin
    a_neg = bus_io.signed_i & bus_io.a_i[WIDTH-1];
    b_neg = bus_io.signed_i & bus_io.b_i[WIDTH-1];
    // Negating the most negative value yields 2^(WIDTH-1), which is the
    // correct magnitude when read as unsigned.
    am_in = a_neg ? -bus_io.a_i : bus_io.a_i;
    bm_in = b_neg ? -bus_io.b_i : bus_io.b_i;
    if (!bus_io.signed_i) begin
      dbz_val = AllOne;
    end else if (bus_io.a_i[WIDTH-1]) begin
      dbz_val = MinNeg;
    end else begin
      dbz_val = MaxPos;
    end
  end

  // One restoring step plus the saturation of the would-be final quotient.
  always_comb begin
    rem_sh  = {rem_q[WIDTH-1:0], dvd_q[Iter-1]};
    fits    = (rem_sh >= {1'b0, bm_q});
    rem_nx  = fits ? (rem_sh - {1'b0, bm_q}) : rem_sh;
    quo_nx  = {quo_q[Iter-2:0], fits};
    qm_ext  = {1'b0, quo_nx};
    q_lo    = quo_nx[WIDTH-1:0];
    fin_q   = q_lo;
    fin_ovf = 1'b0;
    if (!smode_q) begin
      if (qm_ext >= LimU) begin
        fin_q   = AllOne;
        fin_ovf = 1'b1;
      end
    end else if (!neg_q) begin
      if (qm_ext > LimPos) begin
        fin_q   = MaxPos;
        fin_ovf = 1'b1;
      end
    end else begin
      if (qm_ext > LimNeg) begin
        fin_q   = MinNeg;
        fin_ovf = 1'b1;
      end else begin
        // A zero magnitude negates to zero, so no negative zero appears.
        fin_q = -q_lo;
      end
    end
  end

  // Control FSM with the iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      smode_q     <= 1'b0;
      neg_q       <= 1'b0;
      dvd_q       <= '0;
      bm_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      q_q         <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus_io.in_valid) begin
            smode_q    <= bus_io.signed_i;
            neg_q      <= a_neg ^ b_neg;
            bm_q       <= bm_in;
            dvd_q      <= Iter'(am_in) << FRAC;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= CntW'(Iter);
            in_ready_q <= 1'b0;
            if (bus_io.b_i == '0) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              q_q         <= dbz_val;
              ovf_q       <= 1'b0;
              dbz_q       <= 1'b1;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            q_q         <= fin_q;
            ovf_q       <= fin_ovf;
            dbz_q       <= 1'b0;
          end
        end
        StDone: begin
          // Result registers keep their value after consumption.
          if (bus_io.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.q_o       = q_q;
  assign bus_io.ovf_o     = ovf_q;
  assign bus_io.dbz_o     = dbz_q;

endmodule

// File: tb/tb_div_fixed_seq.sv
// Scoreboard bench for div_fixed_seq at WIDTH=32, FRAC=16.
module tb_div_fixed_seq;

  localparam int unsigned Width = 32;
  localparam int unsigned Frac  = 16;
  localparam int          Lat   = Width + Frac;

  typedef struct packed {
    logic [31:0] q;
    logic        ovf;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   acc_cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  div_fixed_seq_if #(.WIDTH(Width)) bus ();

  div_fixed_seq #(
    .WIDTH (Width),
    .FRAC  (Frac)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic ovf, input logic dbz);
    exp_t e;
    e.q   = q;
    e.ovf = ovf;
    e.dbz = dbz;
    return e;
  endfunction

  // Arithmetic reference using 64-bit integer division.
  function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ma;
    logic [63:0] mb;
    logic [63:0] qm;
    bit          neg;
    exp_t        e;
    e = mk(32'h0, 1'b0, 1'b0);
    if (sgn) begin
      ma  = a[31] ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
      mb  = b[31] ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
      neg = a[31] ^ b[31];
    end else begin
      ma  = {32'h0, a};
      mb  = {32'h0, b};
      neg = 1'b0;
    end
    if (b == 32'h0) begin
      e.dbz = 1'b1;
      e.q   = !sgn ? 32'hFFFF_FFFF : (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
      return e;
    end
    qm = (ma << Frac) / mb;
    if (!sgn) begin
      if (qm >= 64'h1_0000_0000) begin
        e.q = 32'hFFFF_FFFF; e.ovf = 1'b1;
      end else begin
        e.q = qm[31:0];
      end
    end else if (!neg) begin
      if (qm > 64'h7FFF_FFFF) begin
        e.q = 32'h7FFF_FFFF; e.ovf = 1'b1;
      end else begin
        e.q = qm[31:0];
      end
    end else begin
      if (qm > 64'h8000_0000) begin
        e.q = 32'h8000_0000; e.ovf = 1'b1;
      end else begin
        e.q = 32'h0 - qm[31:0];
      end
    end
    return e;
  endfunction

  // Result monitor: pops the scoreboard on every consumed result.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_result", 64'(bus.out_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("q", 64'(bus.q_o), 64'(e.q));
        check_eq("ovf", 64'(bus.ovf_o), 64'(e.ovf));
        check_eq("dbz", 64'(bus.dbz_o), 64'(e.dbz));
      end
    end
  end

  task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input bit push);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check_eq("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.signed_i = sgn;
    bus.a_i      = a;
    bus.b_i      = b;
    if (push) sb_q.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int delay);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("out_valid", 64'(bus.out_valid), 64'd1);
    check_eq("latency", 64'(cyc - acc_cyc), 64'(delay));
  endtask

  task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e);
    start_op(sgn, a, b, e, 1'b1);
    wait_valid(e.dbz ? 0 : Lat);
    @(negedge clk);
    check_eq("in_ready_after", 64'(bus.in_ready), 64'd1);
    check_eq("out_valid_after", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;
    n_checks      = 0;
    n_fail        = 0;
    acc_cyc       = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.signed_i  = 1'b0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_q", 64'(bus.q_o), 64'd0);
    check_eq("rst_ovf", 64'(bus.ovf_o), 64'd0);
    check_eq("rst_dbz", 64'(bus.dbz_o), 64'd0);

    // Directed vectors.
    do_op(1'b0, 32'h0000_0003, 32'h0000_0002, mk(32'h0001_8000, 1'b0, 1'b0));
    do_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0002, mk(32'hFFFE_8000, 1'b0, 1'b0));
    do_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, mk(32'h0003_8000, 1'b0, 1'b0));
    do_op(1'b0, 32'h0001_0000, 32'h0000_0001, mk(32'hFFFF_FFFF, 1'b1, 1'b0));
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_0000, mk(32'h7FFF_FFFF, 1'b1, 1'b0));
    do_op(1'b1, 32'hFFFF_8000, 32'h0000_0001, mk(32'h8000_0000, 1'b0, 1'b0));
    do_op(1'b0, 32'h0000_0005, 32'h0000_0000, mk(32'hFFFF_FFFF, 1'b0, 1'b1));
    do_op(1'b1, 32'hFFFF_FFFB, 32'h0000_0000, mk(32'h8000_0000, 1'b0, 1'b1));
    do_op(1'b1, 32'h0000_0000, 32'hFFFF_FFFD, mk(32'h0000_0000, 1'b0, 1'b0));

    // Backpressure: result must hold and new operands must be ignored.
    bus.out_ready = 1'b0;
    start_op(1'b0, 32'h0000_0007, 32'h0000_0002, mk(32'h0003_8000, 1'b0, 1'b0), 1'b1);
    wait_valid(Lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_q", 64'(bus.q_o), 64'h0003_8000);
      check_eq("bp_flags", 64'({bus.ovf_o, bus.dbz_o}), 64'd0);
      check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
      if (i == 4) begin
        bus.in_valid = 1'b1;
        bus.signed_i = 1'b0;
        bus.a_i      = 32'h0000_0009;
        bus.b_i      = 32'h0000_0001;
      end
      if (i == 6) bus.in_valid = 1'b0;
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    check_eq("bp_out_valid_after", 64'(bus.out_valid), 64'd0);
    do_op(1'b0, 32'd100, 32'd4, mk(32'h0019_0000, 1'b0, 1'b0));

    // Reset during CALC cycle 20 discards the operation.
    start_op(1'b0, 32'd1, 32'd3, mk(32'h0, 1'b0, 1'b0), 1'b0);
    while (cyc < acc_cyc + 19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_q", 64'(bus.q_o), 64'd0);
    do_op(1'b0, 32'd1, 32'd3, mk(32'h0000_5555, 1'b0, 1'b0));

    // Random operands against the arithmetic reference.
    for (int k = 0; k < 8; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (k == 3) rb = 32'h0;
      do_op(rs, ra, rb, model(rs, ra, rb));
    end

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_fixed_seq.md
Name: div_fixed_seq

Overview:
- Parametrised iterative restoring divider producing a fixed-point quotient (a<<FRAC)/b, one quotient bit per clock.
- Next generation of the team's Q16.16 unsigned divider, used in the FFT/measurement path for ratio, frequency and amplitude normalisation.
- Adds per-operation signed/unsigned mode, valid/ready handshakes on both sides, and divide-by-zero and overflow detection with saturation.

Parameters:
- WIDTH, 32: operand and quotient width in bits.
- FRAC, 16: fractional bits of the quotient. Legal range is 0 to WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand offer.
- in_ready  out  1  block can accept operands.
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
- a_i  in  WIDTH  dividend.
- b_i  in  WIDTH  divisor.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- q_o  out  WIDTH  quotient; FRAC fractional bits; two's complement when signed.
- ovf_o  out  1  quotient saturated because of range overflow.
- dbz_o  out  1  divisor was zero.

Behaviour:
- Reset: on any rising clk with rst=1, the block goes to IDLE regardless of state; any in-flight operation is discarded. Output reset values: in_ready=1, out_valid=0, q_o=0, ovf_o=0, dbz_o=0.
- Constant: ITER = WIDTH+FRAC.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE). Accept occurs when in_valid and in_ready are both 1 at a rising edge.
- On accept in cycle N:
  - Capture signed_i.
  - Capture magnitudes |a| and |b| as WIDTH-bit unsigned values (signed mode: min-negative magnitude is 2^(WIDTH-1)).
  - Capture the result sign: a_sign XOR b_sign, signed mode only.
- b==0 on accept: go to DONE directly.
  - out_valid=1 from cycle N+1; dbz_o=1, ovf_o=0.
  - q_o = all-ones (unsigned); 0x7F..F if a>=0 (signed); 0x80..0 if a<0 (signed).
- Otherwise go to CALC with an iteration counter of width $clog2(ITER+1), loaded with ITER.
  - Each CALC cycle: shift in the next bit of the (|a|<<FRAC) bit-stream, MSB first, into a partial remainder of WIDTH+1 bits.
  - If partial remainder >= |b|: subtract |b| and shift in quotient bit 1; else shift in 0.
  - Counter decrements by 1 each CALC cycle. Exactly ITER CALC cycles (cycles N+1 .. N+ITER).
- Transition to DONE: form the ITER-bit magnitude Qm, then:
  - Unsigned: if Qm >= 2^WIDTH, q_o = all-ones and ovf_o=1; else q_o = Qm[WIDTH-1:0].
  - Signed, positive result: if Qm > 2^(WIDTH-1)-1, saturate to 0x7F..F with ovf_o=1.
  - Signed, negative result: if Qm > 2^(WIDTH-1), saturate to 0x80..0 with ovf_o=1; else q_o = -Qm.
  - Rounding is truncation toward zero. dbz_o=0.
- DONE: out_valid=1 from cycle N+ITER+1.
  - q_o, ovf_o and dbz_o stay stable while out_valid=1 and out_ready=0; backpressure has no timeout.
  - Edge with out_valid and out_ready both 1: go to IDLE, out_valid=0. in_ready=1 in the following cycle.
  - q_o, ovf_o and dbz_o hold their last values while in IDLE.
- No overlap between operations: in_valid is ignored outside IDLE. A new operation cannot be accepted in the same cycle a result is consumed.
- Throughput: ITER+2 cycles per operation, assuming out_ready=1 and in_valid=1 continuously.
- Zero dividend with nonzero divisor yields q_o=0 with ovf_o=0, including in signed mode (no negative zero).

Test Plan (WIDTH=32, FRAC=16, Q16.16):
- Unsigned 3/2, out_ready=1: accept cycle N -> out_valid first high in cycle N+49; q_o=0x00018000; ovf_o=0; dbz_o=0; in_ready high again in cycle N+50.
- Signed -3/2: a=0xFFFFFFFD, b=0x00000002 -> q_o=0xFFFE8000. Signed -7/-2: a=0xFFFFFFF9, b=0xFFFFFFFE -> q_o=0x00038000.
- Overflow cases:
  - Unsigned a=0x00010000, b=1 -> q_o=0xFFFFFFFF, ovf_o=1.
  - Signed a=0x80000000, b=0xFFFF0000 -> q_o=0x7FFFFFFF, ovf_o=1.
  - Signed a=0xFFFF8000, b=1 -> q_o=0x80000000, ovf_o=0 (exact min).
- Divide-by-zero cases:
  - Unsigned 5/0 -> out_valid in cycle N+1, q_o=0xFFFFFFFF, dbz_o=1.
  - Signed a=0xFFFFFFFB, b=0 -> q_o=0x80000000, dbz_o=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> q_o/flags stable, in_ready=0, and an in_valid pulse during this time is not accepted. Raise out_ready -> next cycle in_ready=1, and the next operation (100/4 -> 0x00190000) completes correctly.
- Reset mid-operation: assert rst in CALC cycle 20 -> next cycle in_ready=1, out_valid=0, q_o=0. A following 1/3 operation gives q_o=0x00005555.
